// File: rtl/mips_wb_pkg.sv
// Shared definitions for the MIPS core's Wishbone-side arbitration logic.
package mips_wb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IM = 2'd1,
      GNT_DM = 2'd2
   } state_e;

   localparam logic [3:0] IM_SEL = 4'hF;
   localparam int unsigned ADR_SHIFT = 2;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating bus-cycle watchdog counter; flags expiry on the last allowed cycle.
module wb_timeout_cnt #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [TO_W-1:0] LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
   localparam logic [TO_W-1:0] MAX  = '1;

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = (TIMEOUT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone bus between the fetch and data ports.
module wb_arbiter
   import mips_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_im_re,
   input  logic [29:0] i_im_adr,
   output logic [31:0] o_im_dout,
   output logic        o_im_ack,
   output logic        o_im_err,
   input  logic        i_dm_we,
   input  logic        i_dm_re,
   input  logic [3:0]  i_dm_sel,
   input  logic [29:0] i_dm_adr,
   input  logic [31:0] i_dm_din,
   output logic [31:0] o_dm_dout,
   output logic        o_dm_ack,
   output logic        o_dm_err,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_ack
);

   state_e r_state;
   logic   r_last_dm;

   logic w_req_im, w_req_dm, w_gnt_im, w_gnt_dm, w_own_req;
   logic w_ack, w_to, w_done, w_leave, w_expire;

   assign w_req_im  = i_im_re;
   assign w_req_dm  = i_dm_we | i_dm_re;
   assign w_gnt_im  = (r_state == GNT_IM);
   assign w_gnt_dm  = (r_state == GNT_DM);
   assign w_own_req = (w_gnt_im & w_req_im) | (w_gnt_dm & w_req_dm);
   // A real ack always wins over a coincident timeout.
   assign w_ack     = w_own_req & i_wb_ack;
   assign w_to      = w_own_req & ~i_wb_ack & w_expire;
   assign w_done    = w_ack | w_to;
   assign w_leave   = (w_gnt_im | w_gnt_dm) & (~w_own_req | w_done);

   wb_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout_cnt (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (w_leave),
      .i_en     (w_own_req & ~i_wb_ack),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_last_dm <= 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_req_im && (!w_req_dm || r_last_dm)) r_state <= GNT_IM;
               else if (w_req_dm)                        r_state <= GNT_DM;
            end
            GNT_IM: if (w_leave) begin
               r_state   <= IDLE;
               r_last_dm <= 1'b0;
            end
            GNT_DM: if (w_leave) begin
               r_state   <= IDLE;
               r_last_dm <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_wb_we   = 1'b0;
      o_wb_sel  = '0;
      o_wb_adr  = '0;
      o_wb_dat  = '0;
      o_im_ack  = 1'b0;
      o_im_err  = 1'b0;
      o_im_dout = '0;
      o_dm_ack  = 1'b0;
      o_dm_err  = 1'b0;
      o_dm_dout = '0;
      if (!i_rst && w_gnt_im) begin
         o_wb_cyc  = w_req_im;
         o_wb_stb  = w_req_im;
         o_wb_sel  = IM_SEL;
         o_wb_adr  = {i_im_adr, {ADR_SHIFT{1'b0}}};
         o_im_ack  = w_done;
         o_im_err  = w_to;
         o_im_dout = w_ack ? i_wb_dat : '0;
      end else if (!i_rst && w_gnt_dm) begin
         o_wb_cyc  = w_req_dm;
         o_wb_stb  = w_req_dm;
         o_wb_we   = i_dm_we;
         o_wb_sel  = i_dm_sel;
         o_wb_adr  = {i_dm_adr, {ADR_SHIFT{1'b0}}};
         o_wb_dat  = i_dm_din;
         o_dm_ack  = w_done;
         o_dm_err  = w_to;
         o_dm_dout = w_ack ? i_wb_dat : '0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (TIMEOUT=4), checked once per cycle.
module tb_wb_arbiter;

   typedef struct packed {
      logic        rst;
      logic        im_re;
      logic [29:0] im_adr;
      logic        dm_we;
      logic        dm_re;
      logic [3:0]  dm_sel;
      logic [29:0] dm_adr;
      logic [31:0] dm_din;
      logic [31:0] wb_dat;
      logic        wb_ack;
   } in_t;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      logic        im_ack;
      logic        im_err;
      logic [31:0] im_dout;
      logic        dm_ack;
      logic        dm_err;
      logic [31:0] dm_dout;
   } out_t;

   typedef struct {
      in_t   vi;
      out_t  ve;
      string name;
   } vec_t;

   localparam logic [29:0] IA = 30'h0000_0040;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   in_t  r_in = '0;
   out_t w_out;
   logic [31:0] o_im_dout, o_dm_dout, o_wb_adr, o_wb_dat;
   logic        o_im_ack, o_im_err, o_dm_ack, o_dm_err, o_wb_cyc, o_wb_stb, o_wb_we;
   logic [3:0]  o_wb_sel;

   int n_chk  = 0;
   int n_fail = 0;
   vec_t tbl[$];

   wb_arbiter #(
      .TIMEOUT (4),
      .TO_W    (3)
   ) dut (
      .i_clk     (clk),
      .i_rst     (r_in.rst),
      .i_im_re   (r_in.im_re),
      .i_im_adr  (r_in.im_adr),
      .o_im_dout (o_im_dout),
      .o_im_ack  (o_im_ack),
      .o_im_err  (o_im_err),
      .i_dm_we   (r_in.dm_we),
      .i_dm_re   (r_in.dm_re),
      .i_dm_sel  (r_in.dm_sel),
      .i_dm_adr  (r_in.dm_adr),
      .i_dm_din  (r_in.dm_din),
      .o_dm_dout (o_dm_dout),
      .o_dm_ack  (o_dm_ack),
      .o_dm_err  (o_dm_err),
      .o_wb_cyc  (o_wb_cyc),
      .o_wb_stb  (o_wb_stb),
      .o_wb_we   (o_wb_we),
      .o_wb_sel  (o_wb_sel),
      .o_wb_adr  (o_wb_adr),
      .o_wb_dat  (o_wb_dat),
      .i_wb_dat  (r_in.wb_dat),
      .i_wb_ack  (r_in.wb_ack)
   );

   assign w_out = {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat,
                   o_im_ack, o_im_err, o_im_dout, o_dm_ack, o_dm_err, o_dm_dout};

   function automatic in_t mk_in(logic rst, logic im_re, logic dm_we, logic dm_re,
                                 logic [3:0] sel, logic [29:0] dadr, logic [31:0] din,
                                 logic ack, logic [31:0] wdat);
      in_t v;
      v = '{rst: rst, im_re: im_re, im_adr: IA, dm_we: dm_we, dm_re: dm_re, dm_sel: sel,
            dm_adr: dadr, dm_din: din, wb_dat: wdat, wb_ack: ack};
      return v;
   endfunction

   function automatic out_t o_idle();
      out_t r;
      r = '0;
      return r;
   endfunction

   function automatic out_t o_im(logic cyc, logic ack, logic err, logic [31:0] dout);
      out_t r;
      r = '0;
      r.cyc = cyc; r.stb = cyc; r.sel = 4'hF; r.adr = 32'h0000_0100;
      r.im_ack = ack; r.im_err = err; r.im_dout = dout;
      return r;
   endfunction

   function automatic out_t o_dm(logic cyc, logic we, logic [3:0] sel, logic [31:0] badr,
                                 logic [31:0] dat, logic ack, logic err, logic [31:0] dout);
      out_t r;
      r = '0;
      r.cyc = cyc; r.stb = cyc; r.we = we; r.sel = sel; r.adr = badr; r.dat = dat;
      r.dm_ack = ack; r.dm_err = err; r.dm_dout = dout;
      return r;
   endfunction

   task automatic add(input in_t vi, input out_t ve, input string name);
      vec_t v;
      v.vi = vi; v.ve = ve; v.name = name;
      tbl.push_back(v);
   endtask

   // Apply one cycle's inputs after the falling edge, check before the next rising edge.
   task automatic step(input in_t vi, input out_t ve, input string name);
      @(negedge clk);
      r_in = vi;
      #1;
      n_chk++;
      if (w_out !== ve) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, w_out, ve);
      end
   endtask

   initial begin
      in_t z, w, b, bi, bd, r, ri, b5;
      z  = mk_in(0, 0, 0, 0, 4'h0, 30'h0, 32'h0, 0, 32'h0);
      w  = mk_in(0, 0, 1, 0, 4'b0011, 30'h100, 32'hCAFEBABE, 0, 32'h0);
      b  = mk_in(0, 1, 0, 1, 4'hF, 30'h200, 32'h55AA55AA, 0, 32'h0);
      bi = mk_in(0, 1, 0, 1, 4'hF, 30'h200, 32'h55AA55AA, 1, 32'h12345678);
      bd = mk_in(0, 1, 0, 1, 4'hF, 30'h200, 32'h55AA55AA, 1, 32'h0BADF00D);

      // Reset with both requesting, then first tie goes to the fetch port.
      add(mk_in(1, 1, 0, 1, 4'h0, 30'h100, 32'h0, 0, 32'h0), o_idle(), "rst0");
      add(mk_in(1, 1, 0, 1, 4'h0, 30'h100, 32'h0, 0, 32'h0), o_idle(), "rst1");
      add(mk_in(0, 1, 0, 1, 4'h0, 30'h100, 32'h0, 0, 32'h0), o_idle(), "arb_latency");
      add(mk_in(0, 1, 0, 0, 4'h0, 30'h0, 32'h0, 1, 32'h12345678),
          o_im(1, 1, 0, 32'h12345678), "first_grant_im");
      add(z, o_idle(), "idle_after_im");
      // Lone write; slave acks on the 4th granted cycle, which is also the timeout cycle.
      add(w, o_idle(), "dw_arb");
      for (int i = 0; i < 3; i++)
         add(w, o_dm(1, 1, 4'b0011, 32'h400, 32'hCAFEBABE, 0, 0, 32'h0), "dw_wait");
      add(mk_in(0, 0, 1, 0, 4'b0011, 30'h100, 32'hCAFEBABE, 1, 32'hDEAD0001),
          o_dm(1, 1, 4'b0011, 32'h400, 32'hCAFEBABE, 1, 0, 32'hDEAD0001), "dw_ack_at_to");
      add(z, o_idle(), "dw_cyc_low");
      // Both requesting continuously: IM, DM, IM, DM with one idle cycle between.
      for (int i = 0; i < 2; i++) begin
         add(b, o_idle(), "rr_idle_im");
         add(b, o_im(1, 0, 0, 32'h0), "rr_im");
         add(bi, o_im(1, 1, 0, 32'h12345678), "rr_im_ack");
         add(b, o_idle(), "rr_idle_dm");
         add(b, o_dm(1, 0, 4'hF, 32'h800, 32'h55AA55AA, 0, 0, 32'h0), "rr_dm");
         add(bd, o_dm(1, 0, 4'hF, 32'h800, 32'h55AA55AA, 1, 0, 32'h0BADF00D), "rr_dm_ack");
      end
      add(z, o_idle(), "rr_end");

      for (int i = 0; i < tbl.size(); i++) step(tbl[i].vi, tbl[i].ve, tbl[i].name);

      // Read that is never acked times out on its 4th granted cycle; pending fetch follows.
      r  = mk_in(0, 0, 0, 1, 4'hF, 30'h200, 32'h0, 0, 32'h0);
      ri = mk_in(0, 1, 0, 1, 4'hF, 30'h200, 32'h0, 0, 32'h0);
      step(r, o_idle(), "to_arb");
      for (int i = 0; i < 3; i++)
         step(ri, o_dm(1, 0, 4'hF, 32'h800, 32'h0, 0, 0, 32'h0), "to_wait");
      step(mk_in(0, 1, 0, 1, 4'hF, 30'h200, 32'h0, 0, 32'hFFFFFFFF),
           o_dm(1, 0, 4'hF, 32'h800, 32'h0, 1, 1, 32'h0), "to_expire");
      step(mk_in(0, 1, 0, 0, 4'h0, 30'h0, 32'h0, 0, 32'h0), o_idle(), "to_idle");
      step(mk_in(0, 1, 0, 0, 4'h0, 30'h0, 32'h0, 1, 32'h12345678),
           o_im(1, 1, 0, 32'h12345678), "to_next_im");

      // Reset in the middle of a data grant: bus drops at once, no ack; next tie goes to IM.
      b5 = mk_in(0, 1, 0, 1, 4'hF, 30'h200, 32'h0, 0, 32'h0);
      step(b5, o_idle(), "mr_arb_dm");
      step(b5, o_dm(1, 0, 4'hF, 32'h800, 32'h0, 0, 0, 32'h0), "mr_dm_cycle1");
      step(mk_in(1, 1, 0, 1, 4'hF, 30'h200, 32'h0, 1, 32'h77777777), o_idle(), "mr_rst");
      step(b5, o_idle(), "mr_release");
      step(mk_in(0, 1, 0, 1, 4'hF, 30'h200, 32'h0, 1, 32'h12345678),
           o_im(1, 1, 0, 32'h12345678), "mr_tie_im");

      // Owner withdraws its request mid-grant: cycle falls, ack from slave is ignored.
      step(mk_in(0, 0, 0, 1, 4'hF, 30'h200, 32'h0, 0, 32'h0), o_idle(), "dr_arb");
      step(mk_in(0, 0, 0, 0, 4'h0, 30'h0, 32'h0, 1, 32'h1), o_idle(), "dr_drop");
      step(z, o_idle(), "dr_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Two-master Wishbone arbiter sharing the single classic Wishbone bus of the MIPS core between the instruction-fetch port (read-only) and the data port (read/write).
- Each master uses the core's simple request interface: adr/we/re/sel/din in, dout/ack out. Each master holds its request until it sees ack.
- Round-robin grant, one transaction per grant, with a bus-timeout watchdog that terminates hung cycles with an error acknowledge.
- Sits between the core's fetch/memory stages and the Wishbone-side request/bus translation.

Parameters:
TIMEOUT, 255, cycles a granted transaction may wait for i_wb_ack before forced termination; 0 disables the watchdog.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous active-high reset
i_im_re  in  1  instruction fetch request
i_im_adr  in  30  instruction word address
o_im_dout  out  32  fetched instruction
o_im_ack  out  1  instruction transaction done (1-cycle pulse)
o_im_err  out  1  instruction transaction timed out (qualifies o_im_ack)
i_dm_we  in  1  data write request
i_dm_re  in  1  data read request
i_dm_sel  in  4  data byte lanes
i_dm_adr  in  30  data word address
i_dm_din  in  32  write data
o_dm_dout  out  32  read data
o_dm_ack  out  1  data transaction done (1-cycle pulse)
o_dm_err  out  1  data transaction timed out (qualifies o_dm_ack)
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe (equal to o_wb_cyc)
o_wb_we  out  1  Wishbone write enable
o_wb_sel  out  4  Wishbone byte select
o_wb_adr  out  32  Wishbone byte address, {i_xx_adr, 2'b00}
o_wb_dat  out  32  Wishbone write data
i_wb_dat  in  32  Wishbone read data
i_wb_ack  in  1  Wishbone acknowledge

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.

FSM states: IDLE, GNT_IM, GNT_DM (registered). Also registered: last_dm (1 = data master served last) and a TO_W-bit counter.

Reset:
- State goes to IDLE, last_dm=1 (so instruction wins the first tie), counter=0.
- While i_rst is high, all outputs are 0 combinationally.
- A reset during an active cycle drops o_wb_cyc immediately. No ack is issued to either master.

Request decoding:
- req_im = i_im_re.
- req_dm = i_dm_we | i_dm_re. If both we and re are high, the access is a write.

Transitions from IDLE (grant is registered, so there is one cycle of arbitration latency):
- Only req_im: go to GNT_IM.
- Only req_dm: go to GNT_DM.
- Both requesting: go to GNT_DM if last_dm=0, else GNT_IM.

While in GNT_x:
- Bus outputs are a combinational mux of the owner's inputs.
  - Instruction owner: we=0, sel=4'hF, dat=0.
  - Data owner: its own we/sel/din.
- o_wb_cyc = o_wb_stb = req of the owner.
- The non-owner's ack and err are held at 0.

Completion (i_wb_ack=1 while in GNT_x):
- Owner's ack = 1 in the same cycle (combinational pass-through). Owner's dout = i_wb_dat.
- Next state is IDLE; last_dm is updated to the owner; counter is cleared.
- Exactly one idle bus cycle separates transactions.

Owner drops its request before ack (protocol violation):
- o_wb_cyc falls in the same cycle.
- Next state is IDLE. No ack. last_dm is updated.

Timeout (TIMEOUT>0):
- Counter increments each GNT_x cycle that has no i_wb_ack.
- When counter == TIMEOUT-1 and still no ack: owner's ack=1 and err=1 in that cycle, owner's dout=0, then next state is IDLE.
- The counter saturates and never wraps.
- If i_wb_ack arrives in the same cycle as the timeout, it is a normal ack with err=0.

Idle outputs: in IDLE, o_wb_cyc/stb/we/sel/adr/dat are all 0, and both douts are 0.

Fairness: with both masters continuously requesting, grants strictly alternate. No master waits longer than one other transaction plus 2 cycles.

Decomposition:
- Shared package (mips_wb_pkg): FSM state encoding (IDLE=2'd0, GNT_IM=2'd1, GNT_DM=2'd2), the instruction-port constant sel 4'hF, and the address-to-byte shift width of 2.
- One natural sub-module, wb_timeout_cnt (clear / enable / saturate, expire flag). Everything else stays flat.

Test Plan:
1. Reset with i_rst=1 for 2 cycles, both requests high → all outputs 0. Release → o_wb_cyc=1 one cycle later, with o_wb_adr={i_im_adr,2'b00}, o_wb_sel=4'hF.
2. Lone data write, i_dm_adr=30'h100, sel=4'b0011, din=32'hCAFEBABE; slave acks 3 cycles after cyc → o_wb_adr=32'h400, we=1. o_dm_ack pulses in the ack cycle. cyc low the next cycle.
3. Both requesting continuously; slave acks each stb after 1 cycle → grant sequence IM, DM, IM, DM. One idle cycle between each pair. o_im_dout is 32'h12345678 when the slave returns it.
4. Data read with the slave never acking, TIMEOUT=4 → o_dm_ack=o_dm_err=1 on the 4th granted cycle, o_dm_dout=0. Next pending IM request is granted afterwards.
5. i_rst asserted mid-transaction (GNT_DM, cycle 2) → o_wb_cyc=0 in the same cycle, no o_dm_ack. After release, the first tie grants IM.
6. i_wb_ack coincides with the timeout cycle → ack=1, err=0, data passed through.
